ili9341_bus_decoder: RTL and testbench
======================================

# ili9341_bus_decoder

Synthesizable responder for the ILI9341 8080-style parallel write bus driven by `graphic_manager`. It samples `tft_csx/dcx/wrx/rdx/data`, decodes commands and parameters, and tracks the CASET/PASET window and RAMWR address counter. It emits one pulse per decoded command and one per pixel written, so benches and on-chip monitors can check pixel traffic without a physical panel.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on every bus input (≥2).
- `MAX_COL`, 319: highest legal column.
- `MAX_ROW`, 239: highest legal row.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `tft_rst` in 1: panel hardware reset, active-low; treated like `reset`, sampled through the synchronizer.
- `tft_csx`, `tft_dcx`, `tft_wrx`, `tft_rdx` in 1 each: bus strobes; `dcx` 0 = command, 1 = data.
- `tft_data` in 16: bus data; commands and parameters use `[7:0]`.
- `cmd_valid` out 1: one-cycle pulse when a command byte is accepted.
- `cmd_code` out 8: last command code; held between pulses.
- `pix_valid` out 1: one-cycle pulse per RAMWR data word.
- `pix_col` out 9: column of the pixel.
- `pix_row` out 8: row of the pixel.
- `pix_data` out 16: RGB565 pixel value.
- `display_on`, `sleep_out` out 1 each: panel status flags.
- `err` out 1: one-cycle error pulse. Present only with the strict option; otherwise tied 0.

## Operation
- **Write event:** a synchronized `wrx` rising edge while synchronized `csx`=0. `dcx` and `data` are taken from the same synchronizer stage as `wrx`.
- **States:** IDLE, CASET, PASET, RAMWR, IGNORE.
- **Command word (`dcx`=0), accepted in any state:** pulse `cmd_valid`, latch `cmd_code`, then by code:
  - 0x2A → CASET, parameter index cleared.
  - 0x2B → PASET, parameter index cleared.
  - 0x2C → RAMWR; address set to (SC, SP).
  - 0x11 → `sleep_out`=1.
  - 0x10 → `sleep_out`=0.
  - 0x29 → `display_on`=1.
  - 0x28 → `display_on`=0.
  - 0x01 → window, flags and address back to defaults.
  - any other code → IGNORE.
- **CASET/PASET:** four data bytes in order: start[15:8], start[7:0], end[15:8], end[7:0]. The window register (SC/EC or SP/EP) is updated atomically after the 4th byte, then state → IDLE. Extra data bytes are ignored.
- **RAMWR:** each data word pulses `pix_valid` with the current (col,row).
  - col increments; at EC it wraps to SC and row increments.
  - At (EC,EP) the address wraps to (SC,SP).
  - RAMWR persists until the next command.
- **`csx` rising** discards a partial CASET/PASET (window unchanged) → IDLE. RAMWR address is kept but the state still → IDLE.
- **Reads:** `rdx` falling edge with `csx`=0 is not supported; no effect on state.
- **Defaults (reset, `tft_rst`=0, SWRESET):** SC=0, EC=MAX_COL, SP=0, EP=MAX_ROW, address (0,0), state IDLE, flags 0.

## Timing
- Reset values: every output 0; `pix_col`, `pix_row`, `pix_data`, `cmd_code` all 0.
- Latency: `cmd_valid`/`pix_valid` assert exactly SYNC_STAGES+2 clk cycles after the first `clk` edge that samples `wrx`=1.
- Bus requirements:
  - `wrx` low and high phases each ≥2 clk periods.
  - `dcx`/`data` stable from the `wrx` falling edge until ≥SYNC_STAGES+1 clk after the rising edge.
- Outputs are registered. `pix_*` is valid only while `pix_valid`=1 and held until the next pixel.
- Asynchronous `reset` mid-transaction aborts it immediately. `tft_rst` low takes effect SYNC_STAGES cycles later.
- A command arriving mid-parameter aborts the parameter sequence; the new command is decoded normally.

## Configuration
- Macro: `ILI9341_DEC_STRICT_EN`.
- **Defined:** `err` pulses (same cycle as the would-be update) when:
  - a completed CASET has start>end or end>MAX_COL,
  - a completed PASET has start>end or end>MAX_ROW,
  - a read strobe is seen,
  - an unknown command is received.
  
  A rejected window is not applied.
- **Undefined:** no checks; windows are applied as received; `err`=0.

## Test plan
- Reset, then SLPOUT 0x11 and DISPON 0x29 → two `cmd_valid` pulses with `cmd_code` 0x11 then 0x29; `sleep_out`=1, `display_on`=1.
- CASET 0x2A params 00,05,00,06; PASET 0x2B params 00,00,00,01; RAMWR plus 5 words 0xF800.. → pixels (5,0), (6,0), (5,1), (6,1), (5,0), `pix_data` matching each word.
- Drive one pixel at col 5, row 0, data 0xFFFF → single `pix_valid` SYNC_STAGES+2 cycles after `wrx` rise, (5,0,0xFFFF).
- CASET with only 2 params then `csx` high, then RAMWR plus 1 word → pixel at (0,0); window still 0..319.
- Strict build: CASET 00,0A,00,05 → `err` pulse; a following RAMWR word lands at (0,0). Non-strict build: window 10..5 applied, `err` stays 0.
- Assert `reset` during the 3rd RAMWR word → outputs 0 at once; after release, RAMWR plus 1 word → (0,0).

Source files
------------

// File: rtl/ili9341_bus_decoder_if.sv
// 8080-style ILI9341 write bus as seen by the decoder, plus the decoder's observation outputs.
interface ili9341_bus_decoder_if;
  logic        tft_rst;
  logic        tft_csx;
  logic        tft_dcx;
  logic        tft_wrx;
  logic        tft_rdx;
  logic [15:0] tft_data;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        pix_valid;
  logic [8:0]  pix_col;
  logic [7:0]  pix_row;
  logic [15:0] pix_data;
  logic        display_on;
  logic        sleep_out;
  logic        err;

  modport master (
    output tft_rst, tft_csx, tft_dcx, tft_wrx, tft_rdx, tft_data,
    input  cmd_valid, cmd_code, pix_valid, pix_col, pix_row, pix_data,
    input  display_on, sleep_out, err
  );

  modport slave (
    input  tft_rst, tft_csx, tft_dcx, tft_wrx, tft_rdx, tft_data,
    output cmd_valid, cmd_code, pix_valid, pix_col, pix_row, pix_data,
    output display_on, sleep_out, err
  );
endinterface

// File: rtl/ili9341_bus_decoder.sv
// ILI9341 parallel write-bus responder: decodes commands, tracks the CASET/PASET window and RAMWR address.
// Define ILI9341_DEC_STRICT_EN to enable window/command/read checking reported on err.
module ili9341_bus_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_COL     = 319,
  parameter int MAX_ROW     = 239
) (
  input logic                  clk,
  input logic                  reset,
  ili9341_bus_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CASET  = 3'd1,
    ST_PASET  = 3'd2,
    ST_RAMWR  = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  // Idle bus: panel reset asserted, strobes high, so nothing looks like an edge after reset.
  localparam logic [20:0] SYNC_RST = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000};
  localparam logic [8:0]  EC_DEF   = 9'(MAX_COL);
  localparam logic [7:0]  EP_DEF   = 8'(MAX_ROW);

  logic [20:0] sync_r [SYNC_STAGES];
  logic [20:0] bus_raw_s;
  logic [20:0] bus_sync_s;
  logic        srst_s, csx_s, dcx_s, wrx_s, rdx_s;
  logic [15:0] data_s;
  logic        csx_prev_r, wrx_prev_r, rdx_prev_r;
  logic        wr_evt_s, cs_rise_s, rd_evt_s;
  logic [19:0] evt_a_r, evt_b_r;
  logic        b_wr_s, b_cs_rise_s, b_rd_s, b_dcx_s;
  logic [15:0] b_data_s;
  logic [15:0] win_start_s, win_end_s;

  state_t      state_r, state_s;
  logic [1:0]  param_idx_r, param_idx_s;
  logic [23:0] param_buf_r, param_buf_s;
  logic [8:0]  sc_r, sc_s, ec_r, ec_s, col_r, col_s;
  logic [7:0]  sp_r, sp_s, ep_r, ep_s, row_r, row_s;
  logic        cmd_valid_r, cmd_valid_s;
  logic [7:0]  cmd_code_r, cmd_code_s;
  logic        pix_valid_r, pix_valid_s;
  logic [8:0]  pix_col_r, pix_col_s;
  logic [7:0]  pix_row_r, pix_row_s;
  logic [15:0] pix_data_r, pix_data_s;
  logic        display_on_r, display_on_s;
  logic        sleep_out_r, sleep_out_s;
  logic        err_r, err_s;

  assign bus_raw_s   = {bus.tft_rst, bus.tft_csx, bus.tft_dcx, bus.tft_wrx, bus.tft_rdx, bus.tft_data};
  assign bus_sync_s  = sync_r[SYNC_STAGES-1];
  assign srst_s      = ~bus_sync_s[20];
  assign csx_s       = bus_sync_s[19];
  assign dcx_s       = bus_sync_s[18];
  assign wrx_s       = bus_sync_s[17];
  assign rdx_s       = bus_sync_s[16];
  assign data_s      = bus_sync_s[15:0];

  assign wr_evt_s    = wrx_s & ~wrx_prev_r & ~csx_s;
  assign cs_rise_s   = csx_s & ~csx_prev_r;
  assign rd_evt_s    = ~rdx_s & rdx_prev_r & ~csx_s;

  assign b_wr_s      = evt_b_r[19];
  assign b_cs_rise_s = evt_b_r[18];
  assign b_rd_s      = evt_b_r[17];
  assign b_dcx_s     = evt_b_r[16];
  assign b_data_s    = evt_b_r[15:0];

  // Window bytes arrive MSB first; the 4th byte completes the end value.
  assign win_start_s = param_buf_r[23:8];
  assign win_end_s   = {param_buf_r[7:0], b_data_s[7:0]};

`ifdef ILI9341_DEC_STRICT_EN
  logic col_bad_s, row_bad_s;
  assign col_bad_s = (win_start_s > win_end_s) || (win_end_s > 16'(MAX_COL));
  assign row_bad_s = (win_start_s > win_end_s) || (win_end_s > 16'(MAX_ROW));
`else
  // Upper window bits only matter to the range checks of the strict build.
  logic unused_s;
  assign unused_s = ^{win_start_s[15:9], win_end_s[15:9]};
`endif

  // Input synchronizer chain; all bus lines travel together so dcx/data align with wrx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= SYNC_RST;
    end else begin
      sync_r[0] <= bus_raw_s;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // Strobe edge detection and two-stage event pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csx_prev_r <= 1'b1;
      wrx_prev_r <= 1'b1;
      rdx_prev_r <= 1'b1;
      evt_a_r    <= 20'h00000;
      evt_b_r    <= 20'h00000;
    end else if (srst_s) begin
      csx_prev_r <= csx_s;
      wrx_prev_r <= wrx_s;
      rdx_prev_r <= rdx_s;
      evt_a_r    <= 20'h00000;
      evt_b_r    <= 20'h00000;
    end else begin
      csx_prev_r <= csx_s;
      wrx_prev_r <= wrx_s;
      rdx_prev_r <= rdx_s;
      evt_a_r    <= {wr_evt_s, cs_rise_s, rd_evt_s, dcx_s, data_s};
      evt_b_r    <= evt_a_r;
    end
  end

  // Decoder next-state and output logic.
  always_comb begin
    state_s      = state_r;
    param_idx_s  = param_idx_r;
    param_buf_s  = param_buf_r;
    sc_s         = sc_r;
    ec_s         = ec_r;
    sp_s         = sp_r;
    ep_s         = ep_r;
    col_s        = col_r;
    row_s        = row_r;
    cmd_valid_s  = 1'b0;
    cmd_code_s   = cmd_code_r;
    pix_valid_s  = 1'b0;
    pix_col_s    = pix_col_r;
    pix_row_s    = pix_row_r;
    pix_data_s   = pix_data_r;
    display_on_s = display_on_r;
    sleep_out_s  = sleep_out_r;
    err_s        = 1'b0;

    if (b_wr_s && !b_dcx_s) begin
      cmd_valid_s = 1'b1;
      cmd_code_s  = b_data_s[7:0];
      param_idx_s = 2'd0;
      state_s     = ST_IDLE;
      case (b_data_s[7:0])
        8'h2A: state_s = ST_CASET;
        8'h2B: state_s = ST_PASET;
        8'h2C: begin
          state_s = ST_RAMWR;
          col_s   = sc_r;
          row_s   = sp_r;
        end
        8'h11: sleep_out_s  = 1'b1;
        8'h10: sleep_out_s  = 1'b0;
        8'h29: display_on_s = 1'b1;
        8'h28: display_on_s = 1'b0;
        8'h01: begin
          sc_s         = 9'd0;
          ec_s         = EC_DEF;
          sp_s         = 8'd0;
          ep_s         = EP_DEF;
          col_s        = 9'd0;
          row_s        = 8'd0;
          display_on_s = 1'b0;
          sleep_out_s  = 1'b0;
        end
        default: begin
          state_s = ST_IGNORE;
`ifdef ILI9341_DEC_STRICT_EN
          err_s   = 1'b1;
`endif
        end
      endcase
    end else if (b_wr_s) begin
      case (state_r)
        ST_CASET, ST_PASET: begin
          if (param_idx_r == 2'd3) begin
            state_s     = ST_IDLE;
            param_idx_s = 2'd0;
            if (state_r == ST_CASET) begin
`ifdef ILI9341_DEC_STRICT_EN
              if (col_bad_s) begin
                err_s = 1'b1;
              end else begin
                sc_s = win_start_s[8:0];
                ec_s = win_end_s[8:0];
              end
`else
              sc_s = win_start_s[8:0];
              ec_s = win_end_s[8:0];
`endif
            end else begin
`ifdef ILI9341_DEC_STRICT_EN
              if (row_bad_s) begin
                err_s = 1'b1;
              end else begin
                sp_s = win_start_s[7:0];
                ep_s = win_end_s[7:0];
              end
`else
              sp_s = win_start_s[7:0];
              ep_s = win_end_s[7:0];
`endif
            end
          end else begin
            param_buf_s = {param_buf_r[15:0], b_data_s[7:0]};
            param_idx_s = param_idx_r + 2'd1;
          end
        end
        ST_RAMWR: begin
          pix_valid_s = 1'b1;
          pix_col_s   = col_r;
          pix_row_s   = row_r;
          pix_data_s  = b_data_s;
          if (col_r == ec_r) begin
            col_s = sc_r;
            if (row_r == ep_r) begin
              row_s = sp_r;
            end else begin
              row_s = row_r + 8'd1;
            end
          end else begin
            col_s = col_r + 9'd1;
          end
        end
        default: state_s = state_r;
      endcase
    end else if (b_cs_rise_s) begin
      state_s     = ST_IDLE;
      param_idx_s = 2'd0;
    end else if (b_rd_s) begin
`ifdef ILI9341_DEC_STRICT_EN
      err_s = 1'b1;
`else
      err_s = 1'b0;
`endif
    end else begin
      state_s = state_r;
    end
  end

  // Decoder state and registered outputs; synchronized tft_rst acts as a soft reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      param_idx_r  <= 2'd0;
      param_buf_r  <= 24'h000000;
      sc_r         <= 9'd0;
      ec_r         <= EC_DEF;
      sp_r         <= 8'd0;
      ep_r         <= EP_DEF;
      col_r        <= 9'd0;
      row_r        <= 8'd0;
      cmd_valid_r  <= 1'b0;
      cmd_code_r   <= 8'h00;
      pix_valid_r  <= 1'b0;
      pix_col_r    <= 9'd0;
      pix_row_r    <= 8'd0;
      pix_data_r   <= 16'h0000;
      display_on_r <= 1'b0;
      sleep_out_r  <= 1'b0;
      err_r        <= 1'b0;
    end else if (srst_s) begin
      state_r      <= ST_IDLE;
      param_idx_r  <= 2'd0;
      param_buf_r  <= 24'h000000;
      sc_r         <= 9'd0;
      ec_r         <= EC_DEF;
      sp_r         <= 8'd0;
      ep_r         <= EP_DEF;
      col_r        <= 9'd0;
      row_r        <= 8'd0;
      cmd_valid_r  <= 1'b0;
      cmd_code_r   <= 8'h00;
      pix_valid_r  <= 1'b0;
      pix_col_r    <= 9'd0;
      pix_row_r    <= 8'd0;
      pix_data_r   <= 16'h0000;
      display_on_r <= 1'b0;
      sleep_out_r  <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      param_idx_r  <= param_idx_s;
      param_buf_r  <= param_buf_s;
      sc_r         <= sc_s;
      ec_r         <= ec_s;
      sp_r         <= sp_s;
      ep_r         <= ep_s;
      col_r        <= col_s;
      row_r        <= row_s;
      cmd_valid_r  <= cmd_valid_s;
      cmd_code_r   <= cmd_code_s;
      pix_valid_r  <= pix_valid_s;
      pix_col_r    <= pix_col_s;
      pix_row_r    <= pix_row_s;
      pix_data_r   <= pix_data_s;
      display_on_r <= display_on_s;
      sleep_out_r  <= sleep_out_s;
      err_r        <= err_s;
    end
  end

  assign bus.cmd_valid  = cmd_valid_r;
  assign bus.cmd_code   = cmd_code_r;
  assign bus.pix_valid  = pix_valid_r;
  assign bus.pix_col    = pix_col_r;
  assign bus.pix_row    = pix_row_r;
  assign bus.pix_data   = pix_data_r;
  assign bus.display_on = display_on_r;
  assign bus.sleep_out  = sleep_out_r;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_ili9341_bus_decoder.sv
// Randomized bench for ili9341_bus_decoder; expected pixels come from a transaction-level window model.
module tb_ili9341_bus_decoder;
  localparam int SS   = 2;
  localparam int MAXC = 319;
  localparam int MAXR = 239;

  logic clk = 1'b0;
  logic reset;

  ili9341_bus_decoder_if bus ();

  ili9341_bus_decoder #(.SYNC_STAGES(SS), .MAX_COL(MAXC), .MAX_ROW(MAXR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] got_pix_q [$];
  logic [32:0] exp_pix_q [$];
  logic [7:0]  got_cmd_q [$];
  logic [7:0]  exp_cmd_q [$];
  int          got_pix_rd = 0;
  int          got_cmd_rd = 0;
  int          got_err    = 0;
  int          exp_err    = 0;

  // Panel model: window, burst position inside RAMWR, flags.
  int m_sc, m_ec, m_sp, m_ep, m_burst;
  bit m_ram, m_disp, m_sleep;

  logic [7:0] flag_tbl [5] = '{8'h11, 8'h10, 8'h29, 8'h28, 8'h00};

  // Output monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.pix_valid) got_pix_q.push_back({bus.pix_col, bus.pix_row, bus.pix_data});
    if (bus.cmd_valid) got_cmd_q.push_back(bus.cmd_code);
    if (bus.err) got_err++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_defaults();
    m_sc = 0; m_ec = MAXC; m_sp = 0; m_ep = MAXR;
    m_burst = 0; m_ram = 1'b0; m_disp = 1'b0; m_sleep = 1'b0;
  endtask

  task automatic wr_word(input logic dc, input logic [15:0] d);
    @(negedge clk);
    bus.tft_csx  = 1'b0;
    bus.tft_dcx  = dc;
    bus.tft_data = d;
    bus.tft_wrx  = 1'b0;
    repeat (2) @(negedge clk);
    bus.tft_wrx  = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    wr_word(1'b0, {8'h00, c});
    exp_cmd_q.push_back(c);
    m_ram = 1'b0;
    case (c)
      8'h2A, 8'h2B: m_ram = 1'b0;
      8'h2C: begin m_ram = 1'b1; m_burst = 0; end
      8'h11: m_sleep = 1'b1;
      8'h10: m_sleep = 1'b0;
      8'h29: m_disp = 1'b1;
      8'h28: m_disp = 1'b0;
      8'h01: model_defaults();
      default: begin
`ifdef ILI9341_DEC_STRICT_EN
        exp_err++;
`endif
      end
    endcase
  endtask

  task automatic send_window(input logic [7:0] c, input int s, input int e);
    bit bad;
    send_cmd(c);
    wr_word(1'b1, {8'h00, s[15:8]});
    wr_word(1'b1, {8'h00, s[7:0]});
    wr_word(1'b1, {8'h00, e[15:8]});
    wr_word(1'b1, {8'h00, e[7:0]});
    bad = (s > e) || (e > ((c == 8'h2A) ? MAXC : MAXR));
`ifdef ILI9341_DEC_STRICT_EN
    if (bad) exp_err++;
`else
    bad = 1'b0;
`endif
    if (!bad && c == 8'h2A) begin m_sc = s; m_ec = e; end
    if (!bad && c == 8'h2B) begin m_sp = s; m_ep = e; end
  endtask

  // Pixel k of a burst sits at linear offset k (mod window area) from (SC,SP).
  task automatic model_pix(input logic [15:0] d);
    int w, h, off;
    if (m_ram) begin
      w   = m_ec - m_sc + 1;
      h   = m_ep - m_sp + 1;
      off = m_burst % (w * h);
      exp_pix_q.push_back({9'(m_sc + off % w), 8'(m_sp + off / w), d});
      m_burst++;
    end
  endtask

  task automatic send_pix(input logic [15:0] d);
    wr_word(1'b1, d);
    model_pix(d);
  endtask

  task automatic cs_release();
    @(negedge clk);
    bus.tft_csx = 1'b1;
    repeat (3) @(negedge clk);
    m_ram = 1'b0;
  endtask

  task automatic rd_strobe();
    @(negedge clk);
    bus.tft_rdx = 1'b0;
    repeat (2) @(negedge clk);
    bus.tft_rdx = 1'b1;
    repeat (4) @(negedge clk);
`ifdef ILI9341_DEC_STRICT_EN
    exp_err++;
`endif
  endtask

  task automatic check_traffic(input string tag);
    repeat (8) @(negedge clk);
    check_eq({tag, "/npix"}, 64'(got_pix_q.size() - got_pix_rd), 64'(exp_pix_q.size()));
    for (int i = 0; i < exp_pix_q.size() && got_pix_rd < got_pix_q.size(); i++) begin
      check_eq({tag, "/pix"}, 64'(got_pix_q[got_pix_rd]), 64'(exp_pix_q[i]));
      got_pix_rd++;
    end
    got_pix_rd = got_pix_q.size();
    exp_pix_q.delete();
    check_eq({tag, "/ncmd"}, 64'(got_cmd_q.size() - got_cmd_rd), 64'(exp_cmd_q.size()));
    for (int i = 0; i < exp_cmd_q.size() && got_cmd_rd < got_cmd_q.size(); i++) begin
      check_eq({tag, "/cmd"}, 64'(got_cmd_q[got_cmd_rd]), 64'(exp_cmd_q[i]));
      got_cmd_rd++;
    end
    got_cmd_rd = got_cmd_q.size();
    exp_cmd_q.delete();
    check_eq({tag, "/err"}, 64'(got_err), 64'(exp_err));
    check_eq({tag, "/flags"}, 64'({bus.display_on, bus.sleep_out}), 64'({m_disp, m_sleep}));
  endtask

  initial begin
    int lat;
    reset        = 1'b1;
    bus.tft_rst  = 1'b1;
    bus.tft_csx  = 1'b1;
    bus.tft_dcx  = 1'b0;
    bus.tft_wrx  = 1'b1;
    bus.tft_rdx  = 1'b1;
    bus.tft_data = 16'h0000;
    model_defaults();
    repeat (3) @(negedge clk);
    check_eq("reset_outs", 64'({bus.cmd_valid, bus.cmd_code, bus.pix_valid, bus.pix_col, bus.pix_row,
                                bus.pix_data, bus.display_on, bus.sleep_out, bus.err}), 64'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    send_cmd(8'h11);
    send_cmd(8'h29);
    check_traffic("flags_on");

    send_window(8'h2A, 5, 6);
    send_window(8'h2B, 0, 1);
    send_cmd(8'h2C);
    for (int i = 0; i < 5; i++) send_pix(16'hF800 + 16'(i));
    check_traffic("win_2x2");

    // Single pixel latency, counted from the first edge that samples wrx high.
    send_cmd(8'h2C);
    @(negedge clk);
    bus.tft_csx = 1'b0; bus.tft_dcx = 1'b1; bus.tft_data = 16'hFFFF; bus.tft_wrx = 1'b0;
    repeat (2) @(negedge clk);
    bus.tft_wrx = 1'b1;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.pix_valid) begin lat = k; break; end
    end
    check_eq("latency", 64'(lat), 64'(SS + 2));
    model_pix(16'hFFFF);
    check_traffic("lat_pix");

    // Partial CASET is discarded by csx rising; reads leave the address alone.
    send_cmd(8'h01);
    send_cmd(8'h2A);
    wr_word(1'b1, 16'h0000);
    wr_word(1'b1, 16'h0005);
    cs_release();
    send_cmd(8'h2C);
    send_pix(16'hA5A5);
    send_pix(16'h5A5A);
    rd_strobe();
    send_pix(16'h1234);
    check_traffic("partial");

    send_cmd(8'h01);
`ifdef ILI9341_DEC_STRICT_EN
    send_window(8'h2A, 10, 5);
    send_cmd(8'h2C);
    send_pix(16'hBEEF);
`else
    send_window(8'h2A, 10, 5);
    send_cmd(8'h2C);
    wr_word(1'b1, 16'hBEEF);
    exp_pix_q.push_back({9'd10, 8'd0, 16'hBEEF});
`endif
    check_traffic("bad_win");
    send_cmd(8'h01);

    send_window(8'h2A, MAXC - 1, MAXC);
    send_window(8'h2B, MAXR - 1, MAXR);
    send_cmd(8'h2C);
    for (int i = 0; i < 5; i++) send_pix(16'h07E0 ^ 16'(i));
    check_traffic("corner");

    // Asynchronous reset in the middle of the third RAMWR word.
    send_cmd(8'h01);
    send_cmd(8'h29);
    send_cmd(8'h2C);
    send_pix(16'h0001);
    send_pix(16'h0002);
    @(negedge clk);
    bus.tft_csx = 1'b0; bus.tft_dcx = 1'b1; bus.tft_data = 16'h0003; bus.tft_wrx = 1'b0;
    repeat (2) @(negedge clk);
    bus.tft_wrx = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("reset_async", 64'({bus.cmd_valid, bus.cmd_code, bus.pix_valid, bus.pix_col, bus.pix_row,
                                 bus.pix_data, bus.display_on, bus.sleep_out, bus.err}), 64'h0);
    model_defaults();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send_cmd(8'h2C);
    send_pix(16'h0077);
    check_traffic("post_reset");

    // Panel hardware reset through the synchronizer.
    send_cmd(8'h29);
    send_cmd(8'h11);
    check_traffic("pre_tft_rst");
    @(negedge clk);
    bus.tft_csx = 1'b1;
    bus.tft_rst = 1'b0;
    repeat (SS + 2) @(negedge clk);
    check_eq("tft_rst", 64'({bus.display_on, bus.sleep_out, bus.cmd_code}), 64'h0);
    bus.tft_rst = 1'b1;
    repeat (4) @(negedge clk);
    model_defaults();

    for (int it = 0; it < 8; it++) begin
      int sc, ec, sp, ep, np;
      logic [7:0] fc;
      fc = flag_tbl[$urandom_range(0, 4)];
      send_cmd(fc);
      if (fc == 8'h00) send_pix(16'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        send_cmd(8'h2A);
        wr_word(1'b1, 16'($urandom_range(0, 255)));
      end
      sc = $urandom_range(0, MAXC);
      ec = $urandom_range(sc, (sc + 3 > MAXC) ? MAXC : sc + 3);
      sp = $urandom_range(0, MAXR);
      ep = $urandom_range(sp, (sp + 3 > MAXR) ? MAXR : sp + 3);
      send_window(8'h2A, sc, ec);
      send_window(8'h2B, sp, ep);
      send_cmd(8'h2C);
      np = $urandom_range(1, 10);
      for (int p = 0; p < np; p++) begin
        send_pix(16'($urandom));
        if ($urandom_range(0, 7) == 0) rd_strobe();
      end
      if ($urandom_range(0, 1) == 1) cs_release();
      check_traffic("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
